id_issue_queue: RTL and testbench



---
 rtl/id_issue_queue_if.sv | 31 +++
 rtl/id_issue_queue.sv | 114 +++++++++++
 tb/tb_id_issue_queue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_issue_queue_if.sv
// Decode-to-issue handshake bundle: one push port, NR_ISSUE lane-packed issue lanes.
interface id_issue_queue_if #(
  parameter int DEPTH     = 4,
  parameter int NR_ISSUE  = 2,
  parameter int SBE_WIDTH = 128
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                          flush_i;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [SBE_WIDTH-1:0]          in_sbe_i;
  logic [31:0]                   in_instr_i;
  logic                          in_ctrl_flow_i;
  logic [NR_ISSUE-1:0]           out_valid_o;
  logic [NR_ISSUE*SBE_WIDTH-1:0] out_sbe_o;
  logic [NR_ISSUE*32-1:0]        out_instr_o;
  logic [NR_ISSUE-1:0]           out_ctrl_flow_o;
  logic [NR_ISSUE-1:0]           out_ack_i;
  logic [CW-1:0]                 count_o;

  modport master (
    output flush_i, in_valid_i, in_sbe_i, in_instr_i, in_ctrl_flow_i, out_ack_i,
    input  in_ready_o, out_valid_o, out_sbe_o, out_instr_o, out_ctrl_flow_o, count_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_sbe_i, in_instr_i, in_ctrl_flow_i, out_ack_i,
    output in_ready_o, out_valid_o, out_sbe_o, out_instr_o, out_ctrl_flow_o, count_o
  );
endinterface

// File: rtl/id_issue_queue.sv
// In-order DEPTH-entry buffer between decode and issue; one push per cycle,
// up to NR_ISSUE oldest entries presented, any in-order prefix retired per cycle.
module id_issue_queue #(
  parameter int DEPTH            = 4,
  parameter int NR_ISSUE         = 2,
  parameter int SBE_WIDTH        = 128,
  parameter int CTRL_FLOW_SERIAL = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  id_issue_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [SBE_WIDTH-1:0] sbe_q   [DEPTH];
  logic [SBE_WIDTH-1:0] sbe_d   [DEPTH];
  logic [31:0]          instr_q [DEPTH];
  logic [31:0]          instr_d [DEPTH];
  logic [DEPTH-1:0]     cf_q, cf_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d, pop_cnt;

  logic [NR_ISSUE-1:0]           lane_vld, lane_cf, acked, pop_mask;
  logic [NR_ISSUE*SBE_WIDTH-1:0] lane_sbe;
  logic [NR_ISSUE*32-1:0]        lane_instr;
  logic [PW-1:0]                 idx;
  logic                          cf_seen, run, ready, push;

  always_comb begin
    lane_vld   = '0;
    lane_cf    = '0;
    lane_sbe   = '0;
    lane_instr = '0;
    idx        = '0;
    cf_seen    = 1'b0;
    for (int k = 0; k < NR_ISSUE; k++) begin
      idx = rd_ptr_q + PW'(k);
      lane_sbe[k*SBE_WIDTH +: SBE_WIDTH] = sbe_q[idx];
      lane_instr[k*32 +: 32]             = instr_q[idx];
      lane_cf[k]                         = cf_q[idx];
      // once a control-flow entry is seen, younger lanes are withheld in serial mode
      lane_vld[k] = (CW'(k) < count_q) && !((CTRL_FLOW_SERIAL != 0) && cf_seen);
      cf_seen     = cf_seen | cf_q[idx];
    end
  end

  always_comb begin
    acked    = q.out_ack_i & lane_vld;
    pop_cnt  = '0;
    pop_mask = '0;
    run      = 1'b1;
    for (int k = 0; k < NR_ISSUE; k++) begin
      if (run && acked[k]) begin
        pop_cnt     = pop_cnt + CW'(1);
        pop_mask[k] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    ready = (count_q < FULL) || (pop_cnt != '0);
    push  = q.in_valid_i & ready;
  end

  always_comb begin
    sbe_d    = sbe_q;
    instr_d  = instr_q;
    cf_d     = cf_q;
    rd_ptr_d = rd_ptr_q + pop_cnt[PW-1:0];
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q - pop_cnt + CW'(push);
    if (q.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (push) begin
      sbe_d[wr_ptr_q]   = q.in_sbe_i;
      instr_d[wr_ptr_q] = q.in_instr_i;
      cf_d[wr_ptr_q]    = q.in_ctrl_flow_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        sbe_q[i]   <= '0;
        instr_q[i] <= '0;
      end
      cf_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sbe_q    <= sbe_d;
      instr_q  <= instr_d;
      cf_q     <= cf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign q.in_ready_o      = ready;
  assign q.out_valid_o     = lane_vld;
  assign q.out_sbe_o       = lane_sbe;
  assign q.out_instr_o     = lane_instr;
  assign q.out_ctrl_flow_o = lane_cf;
  assign q.count_o         = count_q;

  // issue may only retire a contiguous run of valid lanes starting at lane 0
  prefix_ack_a: assert property (@(posedge clk_i) disable iff (rst_i) acked == pop_mask)
    else $warning("id_issue_queue: non-prefix ack, acks above first gap ignored");
endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue: directed vector table, corner sequences, randomized run vs queue model.
module tb_id_issue_queue;
  localparam int DEPTH = 4;
  localparam int NR    = 2;
  localparam int SBW   = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_issue_queue_if #(.DEPTH(DEPTH), .NR_ISSUE(NR), .SBE_WIDTH(SBW)) ifc ();
  id_issue_queue_if #(.DEPTH(DEPTH), .NR_ISSUE(NR), .SBE_WIDTH(SBW)) ifn ();

  id_issue_queue #(.DEPTH(DEPTH), .NR_ISSUE(NR), .SBE_WIDTH(SBW), .CTRL_FLOW_SERIAL(1)) dut (
    .clk_i(clk), .rst_i(rst), .q(ifc.slave)
  );
  id_issue_queue #(.DEPTH(DEPTH), .NR_ISSUE(NR), .SBE_WIDTH(SBW), .CTRL_FLOW_SERIAL(0)) dut_ns (
    .clk_i(clk), .rst_i(rst), .q(ifn.slave)
  );

  typedef struct {
    logic [SBW-1:0] sbe;
    logic [31:0]    instr;
    logic           cf;
  } ent_t;

  typedef struct {
    logic           fl;
    logic           vld;
    logic [SBW-1:0] sbe;
    logic [31:0]    instr;
    logic           cf;
    logic [1:0]     ack;
    logic           rdy;
    logic [2:0]     cnt;
    logic [1:0]     val;
  } vec_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // lanes shown: the oldest entries, stopping after the first control-flow one
  function automatic logic [1:0] model_valid();
    logic [1:0] v = '0;
    bit seen = 0;
    for (int k = 0; k < NR; k++) begin
      if (k < mq.size()) begin
        if (!seen) v[k] = 1'b1;
        if (mq[k].cf) seen = 1;
      end
    end
    return v;
  endfunction

  function automatic vec_t mkv(logic fl, logic vld, logic [SBW-1:0] sbe, logic [31:0] ins,
                               logic cf, logic [1:0] ack, logic rdy, logic [2:0] cnt,
                               logic [1:0] val);
    vec_t v;
    v.fl = fl; v.vld = vld; v.sbe = sbe; v.instr = ins; v.cf = cf;
    v.ack = ack; v.rdy = rdy; v.cnt = cnt; v.val = val;
    return v;
  endfunction

  task automatic check_state();
    logic [1:0] ev;
    ev = model_valid();
    chk("count", 128'(ifc.count_o), 128'(mq.size()));
    chk("out_valid", 128'(ifc.out_valid_o), 128'(ev));
    for (int k = 0; k < NR; k++) begin
      if (ev[k]) begin
        chk($sformatf("lane%0d_sbe", k), ifc.out_sbe_o[k*SBW +: SBW], mq[k].sbe);
        chk($sformatf("lane%0d_instr", k), 128'(ifc.out_instr_o[k*32 +: 32]), 128'(mq[k].instr));
        chk($sformatf("lane%0d_cf", k), 128'(ifc.out_ctrl_flow_o[k]), 128'(mq[k].cf));
      end
    end
  endtask

  // called at a negedge; returns at the next negedge with outputs checked
  task automatic cycle(input logic fl, input logic vld, input logic [SBW-1:0] sbe,
                       input logic [31:0] ins, input logic cf, input logic [1:0] ack,
                       output logic rdy_act);
    logic [1:0] acked;
    int p;
    bit stop;
    logic erdy;
    ent_t e;
    ifc.flush_i = fl; ifc.in_valid_i = vld; ifc.in_sbe_i = sbe;
    ifc.in_instr_i = ins; ifc.in_ctrl_flow_i = cf; ifc.out_ack_i = ack;
    #1;
    acked = ack & model_valid();
    p = 0; stop = 0;
    for (int k = 0; k < NR; k++) begin
      if (!stop && acked[k]) p++;
      else stop = 1;
    end
    erdy = (mq.size() < DEPTH) || (p > 0);
    rdy_act = ifc.in_ready_o;
    chk("in_ready", 128'(rdy_act), 128'(erdy));
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      for (int i = 0; i < p; i++) mq.delete(0);
      if (vld && erdy) begin
        e.sbe = sbe; e.instr = ins; e.cf = cf;
        mq.push_back(e);
      end
    end
    @(negedge clk);
    ifc.flush_i = 0; ifc.in_valid_i = 0; ifc.out_ack_i = '0;
    check_state();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[27];
    logic r;
    logic hv, hcf;
    logic [SBW-1:0] hsbe;
    logic [31:0] hins;
    int n;
    logic [1:0] ack;

    tv[0]  = mkv(0, 1, 128'hA5, 32'h13, 0, 2'b00, 1, 1, 2'b01);
    tv[1]  = mkv(0, 0, 0, 0, 0, 2'b01, 1, 0, 2'b00);
    tv[2]  = mkv(0, 1, 1, 1, 0, 2'b00, 1, 1, 2'b01);
    tv[3]  = mkv(0, 1, 2, 2, 0, 2'b00, 1, 2, 2'b11);
    tv[4]  = mkv(0, 1, 3, 3, 0, 2'b00, 1, 3, 2'b11);
    tv[5]  = mkv(0, 1, 4, 4, 0, 2'b00, 1, 4, 2'b11);
    tv[6]  = mkv(0, 1, 5, 5, 0, 2'b00, 0, 4, 2'b11);
    tv[7]  = mkv(0, 1, 5, 5, 0, 2'b01, 1, 4, 2'b11);
    tv[8]  = mkv(0, 0, 0, 0, 0, 2'b11, 1, 2, 2'b11);
    tv[9]  = mkv(0, 1, 6, 6, 0, 2'b00, 1, 3, 2'b11);
    tv[10] = mkv(0, 0, 0, 0, 0, 2'b11, 1, 1, 2'b01);
    tv[11] = mkv(0, 1, 7, 7, 0, 2'b00, 1, 2, 2'b11);
    tv[12] = mkv(0, 0, 0, 0, 0, 2'b10, 1, 2, 2'b11);
    tv[13] = mkv(0, 0, 0, 0, 0, 2'b11, 1, 0, 2'b00);
    tv[14] = mkv(0, 1, 8, 8, 1, 2'b00, 1, 1, 2'b01);
    tv[15] = mkv(0, 1, 9, 9, 0, 2'b00, 1, 2, 2'b01);
    tv[16] = mkv(0, 1, 10, 10, 0, 2'b00, 1, 3, 2'b01);
    tv[17] = mkv(0, 0, 0, 0, 0, 2'b01, 1, 2, 2'b11);
    tv[18] = mkv(0, 1, 11, 11, 1, 2'b00, 1, 3, 2'b11);
    tv[19] = mkv(0, 0, 0, 0, 0, 2'b01, 1, 2, 2'b11);
    tv[20] = mkv(0, 0, 0, 0, 0, 2'b11, 1, 0, 2'b00);
    tv[21] = mkv(0, 1, 12, 12, 0, 2'b00, 1, 1, 2'b01);
    tv[22] = mkv(0, 1, 13, 13, 0, 2'b00, 1, 2, 2'b11);
    tv[23] = mkv(0, 1, 14, 14, 0, 2'b00, 1, 3, 2'b11);
    tv[24] = mkv(1, 1, 15, 15, 0, 2'b01, 1, 0, 2'b00);
    tv[25] = mkv(0, 1, 16, 16, 0, 2'b00, 1, 1, 2'b01);
    tv[26] = mkv(0, 0, 0, 0, 0, 2'b01, 1, 0, 2'b00);

    ifc.flush_i = 0; ifc.in_valid_i = 0; ifc.in_sbe_i = '0; ifc.in_instr_i = '0;
    ifc.in_ctrl_flow_i = 0; ifc.out_ack_i = '0;
    ifn.flush_i = 0; ifn.in_valid_i = 0; ifn.in_sbe_i = '0; ifn.in_instr_i = '0;
    ifn.in_ctrl_flow_i = 0; ifn.out_ack_i = '0;

    #1 rst = 1'b1;
    #2;
    chk("reset_count", 128'(ifc.count_o), 128'(0));
    chk("reset_valid", 128'(ifc.out_valid_o), 128'(0));
    chk("reset_ready", 128'(ifc.in_ready_o), 128'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      cycle(tv[i].fl, tv[i].vld, tv[i].sbe, tv[i].instr, tv[i].cf, tv[i].ack, r);
      chk($sformatf("vec%0d_ready", i), 128'(r), 128'(tv[i].rdy));
      chk($sformatf("vec%0d_count", i), 128'(ifc.count_o), 128'(tv[i].cnt));
      chk($sformatf("vec%0d_valid", i), 128'(ifc.out_valid_o), 128'(tv[i].val));
    end

    // wrap-around: pushes interleaved with single acks
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 128'(32'h100 + i), 32'h100 + i, 0, 2'b00, r);
      cycle(0, (i % 3) == 0, 128'(32'h200 + i), 32'h200 + i, 0, 2'b01, r);
      chk("wrap_count_bound", 128'(ifc.count_o <= 3'(DEPTH)), 128'(1));
    end

    // non-serial variant shows both lanes behind a branch
    ifn.in_valid_i = 1; ifn.in_instr_i = 32'h63; ifn.in_ctrl_flow_i = 1;
    @(posedge clk); @(negedge clk);
    ifn.in_instr_i = 32'h13; ifn.in_ctrl_flow_i = 0;
    @(posedge clk); @(negedge clk);
    ifn.in_valid_i = 0;
    chk("nonserial_valid", 128'(ifn.out_valid_o), 128'(2'b11));
    chk("nonserial_count", 128'(ifn.count_o), 128'(2));
    ifn.flush_i = 1;
    @(posedge clk); @(negedge clk);
    ifn.flush_i = 0;
    chk("nonserial_flush", 128'(ifn.count_o), 128'(0));

    // randomized run, holding an unaccepted input stable
    hv = 0; hcf = 0; hsbe = '0; hins = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hv && ($urandom_range(0, 9) < 7)) begin
        hv = 1;
        hsbe = {$urandom, $urandom, $urandom, $urandom};
        hins = $urandom;
        hcf = ($urandom_range(0, 3) == 0);
      end
      n = $urandom_range(0, 2);
      ack = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
      cycle($urandom_range(0, 49) == 0, hv, hsbe, hins, hcf, ack, r);
      if (r) hv = 0;
    end

    // asynchronous reset mid-operation
    cycle(0, 1, 128'h1, 32'h1, 0, 2'b00, r);
    cycle(0, 1, 128'h2, 32'h2, 0, 2'b00, r);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 128'(ifc.count_o), 128'(0));
    chk("async_rst_valid", 128'(ifc.out_valid_o), 128'(0));
    chk("async_rst_ready", 128'(ifc.in_ready_o), 128'(1));
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 1, 128'h77, 32'h77, 0, 2'b00, r);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
